hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 105 ++++++++++
 tb/tb_hazard_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline hazard unit: forwarding, load-use stall, branch flush, cache-miss stall
module hazard_controller #(
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int COUNT_WIDTH            = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW,
    input  logic                              RegWriteM,
    input  logic                              RegWriteW,
    input  logic [1:0]                        ResultSrcE,
    input  logic                              PCSrcE,
    input  logic                              CacheMissM,
    input  logic                              RefillDone,
    output logic [1:0]                        ForwardAE,
    output logic [1:0]                        ForwardBE,
    output logic                              StallF,
    output logic                              StallD,
    output logic                              StallE,
    output logic                              StallM,
    output logic                              FlushD,
    output logic                              FlushE,
    output logic                              RefillReq,
    output logic [COUNT_WIDTH-1:0]            StallCount
);

    typedef enum logic [1:0] {RUN, MISS, RESUME} state_t;

    state_t state, state_next;
    logic   lu, ms, pend_lu, pend_br, lu_eff, br_eff;

    // Memory stage wins over writeback because it holds the younger result.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != '0 && RdM == Rs1E)
            ForwardAE = 2'b10;
        else if (RegWriteW && RdW != '0 && RdW == Rs1E)
            ForwardAE = 2'b01;
        if (RegWriteM && RdM != '0 && RdM == Rs2E)
            ForwardBE = 2'b10;
        else if (RegWriteW && RdW != '0 && RdW == Rs2E)
            ForwardBE = 2'b01;
    end

    assign lu = (ResultSrcE == 2'b01) && (RdE != '0) && (RdE == Rs1D || RdE == Rs2D);
    assign ms = (state == RUN && CacheMissM) || state == MISS || state == RESUME;
    assign RefillReq = (state == MISS);

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (CacheMissM) state_next = MISS;
            MISS:    if (RefillDone) state_next = RESUME;
            RESUME:  state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Hazards seen during a memory stall are remembered and released on the first free cycle.
    assign lu_eff = lu || pend_lu;
    assign br_eff = PCSrcE || pend_br;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (ms) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else begin
            StallF = lu_eff && !br_eff;
            StallD = lu_eff && !br_eff;
            FlushD = br_eff;
            FlushE = lu_eff || br_eff;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            StallCount <= '0;
            pend_lu    <= 1'b0;
            pend_br    <= 1'b0;
        end else begin
            state <= state_next;
            if (ms && StallCount != '1)
                StallCount <= StallCount + COUNT_WIDTH'(1);
            pend_lu <= ms ? (pend_lu || lu) : 1'b0;
            pend_br <= ms ? (pend_br || PCSrcE) : 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed plus randomized check of hazard_controller against a behavioural model
module tb_hazard_controller;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk, rst;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, PCSrcE, CacheMissM, RefillDone;
    logic [1:0]    ResultSrcE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, RefillReq;
    logic [CW-1:0] StallCount;

    hazard_controller #(.REGISTER_ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .CacheMissM(CacheMissM), .RefillDone(RefillDone),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .RefillReq(RefillReq), .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Model: waiting for refill, one resume cycle, remembered hazards, saturating stall tally.
    bit m_refill, m_resume, m_plu, m_pbr;
    int m_count;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_lu();
        return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic bit model_ms();
        return m_refill || m_resume || CacheMissM;
    endfunction

    task automatic model_reset();
        m_refill = 0; m_resume = 0; m_plu = 0; m_pbr = 0; m_count = 0;
    endtask

    task automatic check_all();
        bit ms, l, b;
        ms = model_ms();
        l  = model_lu() || m_plu;
        b  = PCSrcE || m_pbr;
        check("ForwardAE", 16'(ForwardAE), 16'(fwd(Rs1E)));
        check("ForwardBE", 16'(ForwardBE), 16'(fwd(Rs2E)));
        check("StallF", 16'(StallF), ms ? 16'd1 : 16'(l && !b));
        check("StallD", 16'(StallD), ms ? 16'd1 : 16'(l && !b));
        check("StallE", 16'(StallE), 16'(ms));
        check("StallM", 16'(StallM), 16'(ms));
        check("FlushD", 16'(FlushD), ms ? 16'd0 : 16'(b));
        check("FlushE", 16'(FlushE), ms ? 16'd0 : 16'(l || b));
        check("RefillReq", 16'(RefillReq), 16'(m_refill));
        check("StallCount", 16'(StallCount), 16'(m_count));
    endtask

    task automatic model_edge();
        bit ms, l;
        ms = model_ms();
        l  = model_lu();
        if (rst) begin
            model_reset();
            return;
        end
        if (ms) begin
            m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
            m_plu = m_plu || l;
            m_pbr = m_pbr || PCSrcE;
        end else begin
            m_plu = 0;
            m_pbr = 0;
        end
        if (m_refill) begin
            if (RefillDone) begin m_refill = 0; m_resume = 1; end
        end else if (m_resume) begin
            m_resume = 0;
        end else if (CacheMissM) begin
            m_refill = 1;
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        finish_cycle();
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, PCSrcE, CacheMissM, RefillDone} = '0;
        ResultSrcE = 2'b00;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Forwarding: memory beats writeback, then writeback alone.
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
        @(negedge clk);
        check("fwd_mem_A", 16'(ForwardAE), 16'd2);
        check("fwd_mem_B", 16'(ForwardBE), 16'd0);
        check_all();
        finish_cycle();
        RegWriteM = 0;
        @(negedge clk);
        check("fwd_wb_A", 16'(ForwardAE), 16'd1);
        check_all();
        finish_cycle();
        clear_inputs();

        // Load-use, then destination x0 suppresses it.
        ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
        @(negedge clk);
        check("lu_stallF", 16'(StallF), 16'd1);
        check("lu_flushE", 16'(FlushE), 16'd1);
        check("lu_flushD", 16'(FlushD), 16'd0);
        check_all();
        finish_cycle();
        RdE = 0; Rs2D = 0;
        @(negedge clk);
        check("lu_x0", 16'({StallF, StallD, FlushE, FlushD}), 16'd0);
        check_all();
        finish_cycle();
        clear_inputs();

        // Miss sequence with a branch pending throughout.
        rst = 1'b1; model_reset(); cycle(); rst = 1'b0;
        PCSrcE = 1;
        for (int c = 0; c <= 6; c++) begin
            CacheMissM = (c == 0);
            RefillDone = (c == 4);
            @(negedge clk);
            check($sformatf("miss_refill_c%0d", c), 16'(RefillReq), 16'(c >= 1 && c <= 4));
            check($sformatf("miss_stall_c%0d", c), 16'({StallF, StallD, StallE, StallM}), (c <= 5) ? 16'hF : 16'h0);
            check($sformatf("miss_flush_c%0d", c), 16'({FlushD, FlushE}), (c == 6) ? 16'd3 : 16'd0);
            check_all();
            finish_cycle();
        end
        clear_inputs();
        @(negedge clk);
        check("miss_count", 16'(StallCount), 16'd6);
        check_all();
        finish_cycle();

        // Saturation, then reset in the middle of a refill.
        CacheMissM = 1;
        for (int c = 0; c < 20; c++) cycle();
        CacheMissM = 0;
        @(negedge clk);
        check("sat_count", 16'(StallCount), 16'(CMAX));
        check_all();
        finish_cycle();
        rst = 1'b1;
        #1;
        check("rst_refill", 16'(RefillReq), 16'd0);
        check("rst_count", 16'(StallCount), 16'd0);
        model_reset();
        cycle();
        rst = 1'b0;

        // Randomized traffic with small register numbers to provoke matches.
        for (int n = 0; n < 400; n++) begin
            Rs1D = AW'($urandom_range(0, 3)); Rs2D = AW'($urandom_range(0, 3));
            Rs1E = AW'($urandom_range(0, 3)); Rs2E = AW'($urandom_range(0, 3));
            RdE  = AW'($urandom_range(0, 3)); RdM  = AW'($urandom_range(0, 3));
            RdW  = AW'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            CacheMissM = ($urandom_range(0, 7) == 0);
            RefillDone = ($urandom_range(0, 3) == 0);
            rst        = ($urandom_range(0, 63) == 0);
            if (rst) model_reset();
            cycle();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
